// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Grant index width; never narrower than one bit.
  function automatic int unsigned gw_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request above i_last_ptr, wrapping.
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned GW   = gw_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [GW-1:0]   i_last_ptr,
  output logic            o_found,
  output logic [GW-1:0]   o_idx
);

  logic [GW-1:0] w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = GW'((32'(i_last_ptr) + k) % NREQ);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locking round-robin arbiter feeding a single UART transmitter,
// with an idle-hold timeout that revokes a stalled grant.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned TIMEOUT = 1024,
  localparam int unsigned GW      = gw_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              timeout_pulse
);

  localparam int unsigned   HW       = $clog2(TIMEOUT);
  localparam logic [HW-1:0] HOLD_MAX = HW'(TIMEOUT - 1);

  state_e        r_state, w_state_nxt;
  logic [GW-1:0] r_grant, w_grant_nxt;
  logic [GW-1:0] r_last, w_last_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_tpulse, w_tpulse_nxt;

  logic          w_pick_found;
  logic [GW-1:0] w_pick_idx;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic [7:0]    w_sel_data;
  logic          w_locked;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .i_req      (req_valid),
    .i_last_ptr (r_last),
    .o_found    (w_pick_found),
    .o_idx      (w_pick_idx)
  );

  assign w_locked = (r_state == ST_LOCKED);

  // Mux the granted requester's byte, valid and last marker.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_grant == GW'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_last   <= GW'(NREQ - 1);
      r_hold   <= '0;
      r_tpulse <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_hold   <= w_hold_nxt;
      r_tpulse <= w_tpulse_nxt;
    end
  end

  // Next state: lock on arbitration win, release on last transfer or idle timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_hold_nxt   = r_hold;
    w_tpulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = ST_LOCKED;
          w_grant_nxt = w_pick_idx;
          w_hold_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        if (w_sel_valid) begin
          w_hold_nxt = '0;
          if (out_ready && w_sel_last) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_grant;
          end
        end else if (r_hold == HOLD_MAX) begin
          w_state_nxt  = ST_IDLE;
          w_last_nxt   = r_grant;
          w_hold_nxt   = '0;
          w_tpulse_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Forwarding path is combinational so a locked byte passes in the same cycle.
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = '0;
    if (w_locked) begin
      out_valid          = w_sel_valid;
      out_data           = w_sel_data;
      req_ready[r_grant] = out_ready;
    end
  end

  assign grant_id      = r_grant;
  assign busy          = w_locked;
  assign timeout_pulse = r_tpulse;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: vector table, corner-case sequences
// and randomized traffic against a packet-level reference model.
module tb_uart_tx_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 1024;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the output, whose turn is next, idle count.
  bit m_locked;
  int m_gid;
  int m_last;
  int m_idle;
  bit m_pulse;

  uart_tx_arb #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_gid    = 0;
    m_last   = N - 1;
    m_idle   = 0;
    m_pulse  = 0;
  endtask

  // Compare DUT against the model, advance the model, then cross one clock edge.
  task automatic tick();
    logic [N-1:0] e_rdy;
    e_rdy = '0;
    if (m_locked) e_rdy[m_gid] = out_ready;
    chk("m_busy", 32'(busy), 32'(m_locked));
    chk("m_grant", 32'(grant_id), 32'(m_gid));
    chk("m_pulse", 32'(timeout_pulse), 32'(m_pulse));
    chk("m_ovalid", 32'(out_valid), m_locked ? 32'(req_valid[m_gid]) : 32'd0);
    chk("m_odata", 32'(out_data), m_locked ? 32'(req_data[8*m_gid +: 8]) : 32'd0);
    chk("m_ready", 32'(req_ready), 32'(e_rdy));
    m_pulse = 0;
    if (m_locked) begin
      if (req_valid[m_gid]) begin
        m_idle = 0;
        if (out_ready && req_last[m_gid]) begin
          m_locked = 0;
          m_last   = m_gid;
        end
      end else if (m_idle + 1 == TO) begin
        m_locked = 0;
        m_last   = m_gid;
        m_idle   = 0;
        m_pulse  = 1;
      end else begin
        m_idle++;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!m_locked && req_valid[c]) begin
          m_locked = 1;
          m_gid    = c;
          m_idle   = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    #1;
    tick();
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic [7:0]   d2;
    logic [N-1:0] rl;
    logic         ordy;
    logic         e_ov;
    logic [7:0]   e_od;
    logic         e_busy;
    logic [1:0]   e_gid;
  } vec_t;

  vec_t tbl[6];
  int   gq[$];
  int   pulses;
  int   hit;

  initial begin
    // Single packet from requester 2: arbitration cycle, three bytes, release.
    tbl[0] = '{4'b0100, 8'h41, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1] = '{4'b0100, 8'h41, 4'b0000, 1'b1, 1'b1, 8'h41, 1'b1, 2'd2};
    tbl[2] = '{4'b0100, 8'h42, 4'b0000, 1'b1, 1'b1, 8'h42, 1'b1, 2'd2};
    tbl[3] = '{4'b0100, 8'h43, 4'b0100, 1'b1, 1'b1, 8'h43, 1'b1, 2'd2};
    tbl[4] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd2};
    tbl[5] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2};

    do_reset();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_pulse", 32'(timeout_pulse), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);

    foreach (tbl[i]) begin
      req_valid = tbl[i].rv;
      req_data  = {8'h00, tbl[i].d2, 8'h00, 8'h00};
      req_last  = tbl[i].rl;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_ovalid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_odata", i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_grant", i), 32'(grant_id), 32'(tbl[i].e_gid));
      tick();
    end

    // Fairness: all requesters stream one-byte packets.
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'hD3C2_B1A0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (busy) gq.push_back(int'(grant_id));
      tick();
    end
    chk("fair_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      chk($sformatf("fair_order%0d", i), 32'(gq[i]), 32'(i % 4));

    // No interleave: requester 1 waits while requester 0 is mid-packet.
    do_reset();
    req_valid = 4'b0011;
    req_last  = 4'b0000;
    req_data  = 32'h0000_B1A0;
    out_ready = 1'b1;
    cyc();
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("nil_grant", 32'(grant_id), 32'd0);
      chk("nil_odata", 32'(out_data), 32'hA0);
      tick();
    end
    req_last = 4'b0001;
    cyc();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    cyc();
    #1;
    chk("nil_next_grant", 32'(grant_id), 32'd1);
    chk("nil_next_odata", 32'(out_data), 32'hB1);
    tick();

    // Timeout: requester 3 sends one byte then goes quiet.
    do_reset();
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    req_data  = 32'h3300_1100;
    out_ready = 1'b1;
    cyc();
    cyc();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    hit = -1;
    for (int c = 0; c < TO + 8; c++) begin
      #1;
      if (timeout_pulse) begin
        hit = c;
        break;
      end
      tick();
    end
    chk("to_cycle", 32'(hit), 32'(TO));
    chk("to_busy", 32'(busy), 32'd0);
    tick();
    #1;
    chk("to_pulse_once", 32'(timeout_pulse), 32'd0);
    chk("to_next_grant", 32'(grant_id), 32'd1);
    chk("to_next_busy", 32'(busy), 32'd1);
    tick();

    // Backpressure: long stall with valid held never times out.
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    req_data  = 32'h005A_0000;
    out_ready = 1'b0;
    cyc();
    pulses = 0;
    for (int c = 0; c < 5000; c++) begin
      #1;
      if (timeout_pulse) pulses++;
      if (out_data !== 8'h5A) pulses++;
      tick();
    end
    chk("bp_no_timeout", 32'(pulses), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready", 32'(req_ready), 32'b0100);
    tick();
    #1;
    chk("bp_release", 32'(busy), 32'd0);
    req_valid = '0;
    tick();

    // Asynchronous reset in the middle of a packet.
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    req_data  = 32'h0000_7700;
    out_ready = 1'b1;
    cyc();
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ovalid", 32'(out_valid), 32'd0);
    chk("ar_odata", 32'(out_data), 32'd0);
    chk("ar_ready", 32'(req_ready), 32'd0);
    chk("ar_grant", 32'(grant_id), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    cyc();
    #1;
    chk("ar_prio", 32'(grant_id), 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      req_last  = N'($urandom) & N'($urandom);
      req_data  = $urandom;
      out_ready = ($urandom_range(3) != 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
